// File: rtl/ccff_chain_loader.sv
// Configuration-chain feeder: accepts bytes over valid/ready and shifts CHAIN_LEN bits MSB-first onto ccff_head.
// Optional CCFF_READBACK_EN captures the bits returning on ccff_tail into rb_data/rb_valid.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done
`ifdef CCFF_READBACK_EN
    ,
    output logic [7:0] rb_data,
    output logic       rb_valid
`endif
);

    localparam int unsigned NB_W = 4;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  bits_left;
    logic [NB_W-1:0]   nbits;
    logic [7:0]        shreg;
    logic [NB_W-1:0]   byte_n_c;

    // Bits to take from the next byte: a full byte or whatever the chain still needs.
    always_comb begin
        byte_n_c = (32'(bits_left) >= 32'd8) ? NB_W'(8) : NB_W'(bits_left);
    end

`ifdef CCFF_READBACK_EN
    logic [NB_W-1:0] byte_bits;
    logic [7:0]      rb_acc;
    logic [7:0]      rb_next_c;
    logic [NB_W-1:0] rb_pos_c;

    // Returning bit lands left-aligned at its position within the current byte.
    always_comb begin
        rb_pos_c  = byte_bits - nbits;
        rb_next_c = rb_acc;
        rb_next_c[3'(NB_W'(7) - rb_pos_c)] = ccff_tail;
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state         <= IDLE;
            bits_left     <= '0;
            nbits         <= '0;
            shreg         <= '0;
            cfg_ready     <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef CCFF_READBACK_EN
            byte_bits     <= '0;
            rb_acc        <= '0;
            rb_data       <= '0;
            rb_valid      <= 1'b0;
`endif
        end else begin
`ifdef CCFF_READBACK_EN
            rb_valid <= 1'b0;
`endif
            if (abort) begin
                state         <= IDLE;
                bits_left     <= '0;
                nbits         <= '0;
                cfg_ready     <= 1'b0;
                ccff_head     <= 1'b0;
                ccff_shift_en <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        done <= 1'b0;
                        if (start) begin
                            state     <= LOAD;
                            bits_left <= CNT_W'(CHAIN_LEN);
                            cfg_ready <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (cfg_valid && cfg_ready) begin
                            state         <= SHIFT;
                            cfg_ready     <= 1'b0;
                            ccff_shift_en <= 1'b1;
                            ccff_head     <= cfg_data[7];
                            shreg         <= {cfg_data[6:0], 1'b0};
                            nbits         <= byte_n_c;
`ifdef CCFF_READBACK_EN
                            byte_bits     <= byte_n_c;
                            rb_acc        <= '0;
`endif
                        end
                    end
                    SHIFT: begin
                        if (bits_left != '0) begin
                            bits_left <= bits_left - CNT_W'(1);
                        end
                        nbits <= nbits - NB_W'(1);
`ifdef CCFF_READBACK_EN
                        rb_acc <= rb_next_c;
`endif
                        if (nbits == NB_W'(1)) begin
                            ccff_shift_en <= 1'b0;
                            ccff_head     <= 1'b0;
`ifdef CCFF_READBACK_EN
                            rb_data       <= rb_next_c;
                            rb_valid      <= 1'b1;
`endif
                            if (bits_left <= CNT_W'(1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= LOAD;
                                cfg_ready <= 1'b1;
                            end
                        end else begin
                            ccff_head <= shreg[7];
                            shreg     <= {shreg[6:0], 1'b0};
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader: two instances (CHAIN_LEN 8 and 10) feeding modelled config chains.
// Expected bit streams, chain contents and readback bytes come from a bit-queue level model of each session.
module tb_ccff_chain_loader;

    localparam int unsigned LEN0 = 8;
    localparam int unsigned LEN1 = 10;

    logic        prog_clk = 1'b0;
    logic        pReset   = 1'b0;
    logic        start         [2];
    logic        abort_s       [2];
    logic [7:0]  cfg_data      [2];
    logic        cfg_valid     [2];
    logic        cfg_ready     [2];
    logic        ccff_head     [2];
    logic        ccff_shift_en [2];
    logic        ccff_tail     [2];
    logic        busy          [2];
    logic        done          [2];
`ifdef CCFF_READBACK_EN
    logic [7:0]  rb_data       [2];
    logic        rb_valid      [2];
`endif

    logic [15:0] chain     [2];
    logic [15:0] exp_chain [2];
    logic [15:0] pre_val   [2];
    logic        pre_req   [2];
    logic [7:0]  bq[$];
    int          force_gap = -1;
    int          checks = 0;
    int          errors = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(LEN0)) u_dut0 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start[0]), .abort(abort_s[0]),
        .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
        .ccff_head(ccff_head[0]), .ccff_shift_en(ccff_shift_en[0]), .ccff_tail(ccff_tail[0]),
        .busy(busy[0]), .done(done[0])
`ifdef CCFF_READBACK_EN
        , .rb_data(rb_data[0]), .rb_valid(rb_valid[0])
`endif
    );

    ccff_chain_loader #(.CHAIN_LEN(LEN1)) u_dut1 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start[1]), .abort(abort_s[1]),
        .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
        .ccff_head(ccff_head[1]), .ccff_shift_en(ccff_shift_en[1]), .ccff_tail(ccff_tail[1]),
        .busy(busy[1]), .done(done[1])
`ifdef CCFF_READBACK_EN
        , .rb_data(rb_data[1]), .rb_valid(rb_valid[1])
`endif
    );

    // Downstream chain: new bit enters at bit 0, the oldest bit leaves at the top.
    assign ccff_tail[0] = chain[0][LEN0-1];
    assign ccff_tail[1] = chain[1][LEN1-1];

    always @(posedge prog_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pre_req[i])            chain[i] <= pre_val[i];
            else if (ccff_shift_en[i]) chain[i] <= {chain[i][14:0], ccff_head[i]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge prog_clk);
    endtask

    function automatic int lenof(input int s);
        return (s == 0) ? LEN0 : LEN1;
    endfunction

    task automatic check_quiet(input int s, input string tag);
        check({tag, "_busy"},  32'(busy[s]), 0);
        check({tag, "_ready"}, 32'(cfg_ready[s]), 0);
        check({tag, "_sen"},   32'(ccff_shift_en[s]), 0);
        check({tag, "_done"},  32'(done[s]), 0);
    endtask

    // One load session; stop_at = global bit index where abort/reset hits (-1: none).
    task automatic session(input int s, input int stop_at, input bit use_rst);
        int          len;
        int          left;
        int          g;
        int          n;
        int          gap;
        bit          stopped;
        logic [15:0] prev;
        logic [15:0] mask;
        logic [7:0]  b;
        logic [7:0]  er;
        len     = lenof(s);
        left    = len;
        g       = 0;
        stopped = 1'b0;
        prev    = exp_chain[s];
        mask    = 16'((32'd1 << len) - 1);
        er      = '0;
        check_quiet(s, "idle");
        start[s] = 1'b1;
        cyc();
        start[s] = 1'b0;
        check("load_ready", 32'(cfg_ready[s]), 1);
        check("load_busy",  32'(busy[s]), 1);
        while (left > 0 && !stopped) begin
            gap = (force_gap >= 0) ? force_gap : int'($urandom_range(0, 3));
            force_gap = -1;
            for (int i = 0; i < gap; i++) begin
                cfg_valid[s] = 1'b0;
                cfg_data[s]  = 8'($urandom);
                start[s]     = 1'($urandom_range(0, 1));
                cyc();
                check("bp_ready", 32'(cfg_ready[s]), 1);
                check("bp_sen",   32'(ccff_shift_en[s]), 0);
            end
            b = (bq.size() > 0) ? bq.pop_front() : 8'($urandom);
            cfg_valid[s] = 1'b1;
            cfg_data[s]  = b;
            start[s]     = 1'b0;
            cyc();
            n = (left < 8) ? left : 8;
            for (int k = 0; k < n; k++) begin
                check("sen",   32'(ccff_shift_en[s]), 1);
                check("head",  32'(ccff_head[s]), 32'(b[7-k]));
                check("ready_in_shift", 32'(cfg_ready[s]), 0);
                check("done_in_shift",  32'(done[s]), 0);
                if (g == stop_at) begin
                    cfg_valid[s] = 1'b0;
                    start[s]     = 1'b0;
                    if (use_rst) begin
                        pReset = 1'b0;
                        #1;
                        check_quiet(s, "rst");
                        check("rst_head", 32'(ccff_head[s]), 0);
                        cyc();
                        pReset = 1'b1;
                    end else begin
                        exp_chain[s] = {exp_chain[s][14:0], b[7-k]};
                        abort_s[s] = 1'b1;
                        cyc();
                        abort_s[s] = 1'b0;
                        check_quiet(s, "abort");
                    end
                    stopped = 1'b1;
                    break;
                end
                exp_chain[s] = {exp_chain[s][14:0], b[7-k]};
                cfg_valid[s] = 1'($urandom_range(0, 1));
                cfg_data[s]  = 8'($urandom);
                start[s]     = 1'($urandom_range(0, 1));
                g++;
                cyc();
            end
            if (!stopped) begin
                left -= n;
                cfg_valid[s] = 1'b0;
                start[s]     = 1'b0;
`ifdef CCFF_READBACK_EN
                er = '0;
                for (int k = 0; k < n; k++) er[7-k] = prev[len-1-(g-n+k)];
                check("rb_valid", 32'(rb_valid[s]), 1);
                check("rb_data",  32'(rb_data[s]), 32'(er));
`endif
                if (left > 0) begin
                    check("gap_ready", 32'(cfg_ready[s]), 1);
                    check("gap_sen",   32'(ccff_shift_en[s]), 0);
                    check("gap_done",  32'(done[s]), 0);
                end else begin
                    check("done_pulse", 32'(done[s]), 1);
                    check("done_busy",  32'(busy[s]), 1);
                    check("done_sen",   32'(ccff_shift_en[s]), 0);
                    check("done_ready", 32'(cfg_ready[s]), 0);
                    cfg_valid[s] = 1'b1;
                    cfg_data[s]  = 8'($urandom);
                    start[s]     = 1'($urandom_range(0, 1));
                    cyc();
                    start[s] = 1'b0;
                    check_quiet(s, "after_done");
                    cyc();
                    check("no_extra_ready", 32'(cfg_ready[s]), 0);
                    cfg_valid[s] = 1'b0;
                end
            end
        end
        if (stopped) begin
            for (int i = 0; i < 3; i++) begin
                cyc();
                check_quiet(s, "post_stop");
            end
        end
        check("chain", 32'(chain[s] & mask), 32'(exp_chain[s] & mask));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort_s[i] = 1'b0; cfg_valid[i] = 1'b0;
            cfg_data[i] = 8'h00; pre_req[i] = 1'b1;
        end
        pre_val[0] = 16'h003C;
        pre_val[1] = 16'($urandom);
        exp_chain[0] = pre_val[0];
        exp_chain[1] = pre_val[1];
        cyc();
        cyc();
        for (int s = 0; s < 2; s++) begin
            check_quiet(s, "reset");
            check("reset_head", 32'(ccff_head[s]), 0);
`ifdef CCFF_READBACK_EN
            check("reset_rb_data",  32'(rb_data[s]), 0);
            check("reset_rb_valid", 32'(rb_valid[s]), 0);
`endif
        end
        pre_req[0] = 1'b0;
        pre_req[1] = 1'b0;
        pReset = 1'b1;
        cyc();

        bq.push_back(8'hA5);
        session(0, -1, 1'b0);
        bq.push_back(8'h00);
        session(0, -1, 1'b0);

        bq.push_back(8'hFF);
        bq.push_back(8'hC0);
        force_gap = 5;
        session(1, -1, 1'b0);

        // start with abort in IDLE must stay idle
        start[0]   = 1'b1;
        abort_s[0] = 1'b1;
        cyc();
        start[0]   = 1'b0;
        abort_s[0] = 1'b0;
        check_quiet(0, "start_abort");

        session(0, 3, 1'b0);
        session(0, -1, 1'b0);
        session(1, 3, 1'b1);
        session(1, -1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            int s;
            int stop;
            s    = int'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lenof(s) - 1)) : -1;
            session(s, stop, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
